// File: rtl/gcd_controller.sv
// Control FSM for the subtract-compare GCD datapath with start/busy/done/err handshake and iteration watchdog.
// Define GCD_ITER_CNT_EN to expose the iteration count of the last run on iter_cnt.
module gcd_controller #(
  parameter int MAX_ITER = 16,
  parameter int CW       = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic eqflg,
  input  logic itflg,
  output logic xmsel,
  output logic ymsel,
  output logic xld,
  output logic yld,
  output logic gld,
  output logic busy,
  output logic done,
  output logic err
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CW-1:0] iter_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          load_q, load_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          calc_s;
  logic          wd_hit_s;
  logic          sub_s;

  assign wd_hit_s = (cnt_q == CW'(MAX_ITER));

  // Next-state, watchdog counter and registered handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        // The watchdog exit is what keeps the counter from ever passing MAX_ITER
        if (eqflg) begin
          state_d = S_DONE;
        end else if (wd_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_CALC;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_CALC);
    load_d = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    if ((state_d == S_DONE) || (state_d == S_ERR)) iter_d = cnt_q;
    else                                          iter_d = iter_q;
  end

  // State and output registers; clr aborts immediately with no pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  // CALC strobes must follow the flags of the current cycle, so they stay Mealy
  assign calc_s = (state_q == S_CALC);
  assign sub_s  = calc_s & ~eqflg & ~wd_hit_s;

  assign xmsel = load_q;
  assign ymsel = load_q;
  assign xld   = load_q | (sub_s & ~itflg);
  assign yld   = load_q | (sub_s & itflg);
  assign gld   = calc_s & eqflg;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
`ifdef GCD_ITER_CNT_EN
  assign iter_cnt = iter_q;
`endif

endmodule
